// File: rtl/clock_pkg.sv
// Shared types and constants for the hh:mm time-set path.
// State encoding, field widths and moduli, blink_field codes.
package clock_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int HOUR_MOD = 24;
  localparam int MIN_MOD  = 60;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    COMMIT    = 2'd3
  } set_state_t;

  localparam logic [1:0] BLINK_NONE = 2'b00;
  localparam logic [1:0] BLINK_HOUR = 2'b01;
  localparam logic [1:0] BLINK_MIN  = 2'b10;

endpackage

// File: rtl/wrap_step.sv
// Modular add/subtract of a step (1..MOD-1) on a W-bit value in 0..MOD-1.
// Ports: i_val value, i_step step, i_up 1=add 0=subtract, o_val result.
module wrap_step #(
  parameter int W   = 6,
  parameter int MOD = 60
) (
  input  logic [W-1:0] i_val,
  input  logic [W-1:0] i_step,
  input  logic         i_up,
  output logic [W-1:0] o_val
);

  localparam logic [W:0]   M1 = (W+1)'(MOD);
  localparam logic [W-1:0] MW = W'(MOD);

  logic [W:0]   w_raw;
  logic [W:0]   w_sum;
  logic [W-1:0] w_dif;

  always_comb begin
    w_raw = {1'b0, i_val} + {1'b0, i_step};
    w_sum = (w_raw >= M1) ? (w_raw - M1) : w_raw;
    // low W bits are exact once the borrow is undone by adding MOD
    w_dif = i_val - i_step;
    if (i_val < i_step) w_dif = w_dif + MW;
    o_val = i_up ? w_sum[W-1:0] : w_dif;
  end

endmodule

// File: rtl/rot_time_setter.sv
// Interactive hh:mm set sequence driven by rotary steps and push button.
// Ports: clk, rst_n, event_rot_l/r, btn_press, cur_hour/min in;
// set_hour/min, load, editing, blink_field out. Option: ROT_ACCEL_EN.
module rot_time_setter
  import clock_pkg::*;
#(
  parameter int TIMEOUT_CYC = 500_000_000
`ifdef ROT_ACCEL_EN
  ,
  parameter int ACCEL_WIN   = 10_000_000,
  parameter int ACCEL_STEP  = 5
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              event_rot_l,
  input  logic              event_rot_r,
  input  logic              btn_press,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  output logic [HOUR_W-1:0] set_hour,
  output logic [MIN_W-1:0]  set_min,
  output logic              load,
  output logic              editing,
  output logic [1:0]        blink_field
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  set_state_t r_state;
  set_state_t w_next;

  logic [TW-1:0]     r_tmo;
  logic              w_pulse;
  logic              w_rot;
  logic              w_tmo_hit;
  logic [HOUR_W-1:0] w_hour_nx;
  logic [MIN_W-1:0]  w_min_nx;
  logic [MIN_W-1:0]  w_min_step;

  assign w_pulse   = btn_press | event_rot_l | event_rot_r;
  // both directions at once cancel; button steals the cycle
  assign w_rot     = (event_rot_l ^ event_rot_r) & ~btn_press;
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYC - 1)) & ~w_pulse;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (btn_press) w_next = EDIT_HOUR;
      end
      EDIT_HOUR: begin
        if (btn_press)      w_next = EDIT_MIN;
        else if (w_tmo_hit) w_next = IDLE;
      end
      EDIT_MIN: begin
        if (btn_press)      w_next = COMMIT;
        else if (w_tmo_hit) w_next = IDLE;
      end
      COMMIT: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (w_pulse || (w_next != r_state) || !editing) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

`ifdef ROT_ACCEL_EN
  localparam int GW = $clog2(ACCEL_WIN + 1);

  logic [GW-1:0] r_gap;
  logic          r_prev_vld;
  logic          r_prev_up;
  logic          w_fast;

  // r_gap holds cycles since the last minute step, saturating at ACCEL_WIN
  assign w_fast = r_prev_vld & (r_prev_up == event_rot_r) &
                  (r_gap < GW'(ACCEL_WIN));
  assign w_min_step = w_fast ? MIN_W'(ACCEL_STEP) : MIN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap      <= '0;
      r_prev_vld <= 1'b0;
      r_prev_up  <= 1'b0;
    end else if (r_state != EDIT_MIN) begin
      r_gap      <= '0;
      r_prev_vld <= 1'b0;
    end else if (w_rot) begin
      r_gap      <= GW'(1);
      r_prev_vld <= 1'b1;
      r_prev_up  <= event_rot_r;
    end else if (r_gap < GW'(ACCEL_WIN)) begin
      r_gap <= r_gap + GW'(1);
    end
  end
`else
  assign w_min_step = MIN_W'(1);
`endif

  wrap_step #(.W(HOUR_W), .MOD(HOUR_MOD)) u_hour (
    .i_val  (set_hour),
    .i_step (HOUR_W'(1)),
    .i_up   (event_rot_r),
    .o_val  (w_hour_nx)
  );

  wrap_step #(.W(MIN_W), .MOD(MIN_MOD)) u_min (
    .i_val  (set_min),
    .i_step (w_min_step),
    .i_up   (event_rot_r),
    .o_val  (w_min_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_hour <= '0;
      set_min  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (btn_press) begin
            set_hour <= cur_hour;
            set_min  <= cur_min;
          end
        end
        EDIT_HOUR: begin
          if (w_rot) set_hour <= w_hour_nx;
        end
        EDIT_MIN: begin
          if (w_rot) set_min <= w_min_nx;
        end
        default: ;
      endcase
    end
  end

  assign load    = (r_state == COMMIT);
  assign editing = (r_state == EDIT_HOUR) | (r_state == EDIT_MIN);

  always_comb begin
    blink_field = BLINK_NONE;
    unique case (1'b1)
      (r_state == EDIT_HOUR): blink_field = BLINK_HOUR;
      (r_state == EDIT_MIN):  blink_field = BLINK_MIN;
      default:                blink_field = BLINK_NONE;
    endcase
  end

endmodule

// File: tb/tb_rot_time_setter.sv
// Randomized bench for rot_time_setter against a cycle-indexed model.
// Covers wrap, simultaneous events, timeout, async reset, ROT_ACCEL_EN.
module tb_rot_time_setter;

  localparam int TO = 100;
`ifdef ROT_ACCEL_EN
  localparam int AW = 20;
  localparam int AS = 5;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ev_l = 1'b0;
  logic       ev_r = 1'b0;
  logic       btn = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic       load;
  logic       editing;
  logic [1:0] blink_field;

  always #5 clk = ~clk;

  rot_time_setter #(
    .TIMEOUT_CYC (TO)
`ifdef ROT_ACCEL_EN
    ,
    .ACCEL_WIN   (AW),
    .ACCEL_STEP  (AS)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .event_rot_l (ev_l),
    .event_rot_r (ev_r),
    .btn_press   (btn),
    .cur_hour    (cur_hour),
    .cur_min     (cur_min),
    .set_hour    (set_hour),
    .set_min     (set_min),
    .load        (load),
    .editing     (editing),
    .blink_field (blink_field)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // model: md 0 idle, 1 hour edit, 2 minute edit, 3 commit
  int md = 0;
  int mh = 0;
  int mm = 0;
  int cyc = 0;
  int t_act = 0;
  bit pv = 0;
  bit pdir = 0;
  int tp = 0;

  task automatic model_edge(input bit l, input bit r, input bit b);
    bit pulse;
    bit rot;
    int pm;
    int s;
    pulse = b | l | r;
    rot = (l ^ r) && !b;
    pm = md;
    cyc++;
    case (pm)
      0: if (b) begin
        md = 1;
        mh = int'(cur_hour);
        mm = int'(cur_min);
      end
      1: begin
        if (b) md = 2;
        else if (rot) mh = r ? (mh + 1) % 24 : (mh + 23) % 24;
        else if (!pulse && (cyc - t_act) == TO) md = 0;
      end
      2: begin
        if (b) md = 3;
        else if (rot) begin
          s = 1;
`ifdef ROT_ACCEL_EN
          if (pv && pdir == r && (cyc - tp) < AW) s = AS;
          pv = 1;
          pdir = r;
          tp = cyc;
`endif
          mm = r ? (mm + s) % 60 : (mm + 60 - s) % 60;
        end
        else if (!pulse && (cyc - t_act) == TO) md = 0;
      end
      default: md = 0;
    endcase
    if (pulse || md != pm) t_act = cyc;
    if (md != 2) pv = 0;
  endtask

  task automatic check_all();
    chk("set_hour", 32'(set_hour), 32'(mh));
    chk("set_min", 32'(set_min), 32'(mm));
    chk("load", 32'(load), 32'(md == 3));
    chk("editing", 32'(editing), 32'(md == 1 || md == 2));
    chk("blink", 32'(blink_field),
        (md == 1) ? 32'd1 : (md == 2) ? 32'd2 : 32'd0);
  endtask

  task automatic step(input bit l, input bit r, input bit b);
    @(negedge clk);
    ev_l = l;
    ev_r = r;
    btn = b;
    @(posedge clk);
    model_edge(l, r, b);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hour"}, 32'(set_hour), 0);
    chk({tag, "_min"}, 32'(set_min), 0);
    chk({tag, "_load"}, 32'(load), 0);
    chk({tag, "_edit"}, 32'(editing), 0);
    chk({tag, "_blink"}, 32'(blink_field), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ev_l = 0;
    ev_r = 0;
    btn = 0;
    #2;
    rst_n = 0;
    #1;
    check_zero("arst");
    md = 0;
    mh = 0;
    mm = 0;
    pv = 0;
    @(posedge clk);
    #1;
    check_zero("arst_hold");
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #1;
    check_zero("por");
    repeat (3) @(posedge clk);
    #1;
    check_zero("por_hold");
    @(negedge clk);
    rst_n = 1;

    // 23:59 wraps to 00:00 and commits
    cur_hour = 23;
    cur_min = 59;
    step(0, 0, 1);
    chk("cap_hour", 32'(set_hour), 23);
    step(0, 1, 0);
    chk("hour_wrap_up", 32'(set_hour), 0);
    step(0, 0, 1);
    step(0, 1, 0);
    chk("min_wrap_up", 32'(set_min), 0);
    step(0, 0, 1);
    chk("commit_load", 32'(load), 1);
    step(0, 0, 0);
    chk("load_one_cycle", 32'(load), 0);
    chk("hold_hour", 32'(set_hour), 0);
    idle(3);

    // minute 0 down to 59, then l+r together is no step
    cur_hour = 0;
    cur_min = 0;
    step(0, 0, 1);
    step(1, 0, 0);
    chk("hour_wrap_dn", 32'(set_hour), 23);
    step(0, 0, 1);
    step(1, 0, 0);
    chk("min_wrap_dn", 32'(set_min), 59);
    step(1, 1, 0);
    chk("lr_cancel", 32'(set_min), 59);
    step(0, 0, 1);
    step(0, 0, 0);

    // btn beats rot in EDIT_HOUR
    cur_hour = 7;
    cur_min = 30;
    step(0, 0, 1);
    step(0, 1, 1);
    chk("btn_wins_state", 32'(blink_field), 2);
    chk("btn_wins_hour", 32'(set_hour), 7);

    // timeout from EDIT_MIN after TO idle cycles
    idle(TO - 1);
    chk("tmo_not_yet", 32'(editing), 1);
    step(0, 0, 0);
    chk("tmo_abort", 32'(editing), 0);
    chk("tmo_noload", 32'(load), 0);
    idle(5);

    // async reset in EDIT_MIN
    cur_hour = 12;
    cur_min = 12;
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 0);
    do_reset();
    idle(5);

`ifdef ROT_ACCEL_EN
    cur_hour = 1;
    cur_min = 56;
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 0);
    chk("acc_first", 32'(set_min), 57);
    idle(9);
    step(0, 1, 0);
    chk("acc_fast", 32'(set_min), 2);
    idle(29);
    step(0, 1, 0);
    chk("acc_slow", 32'(set_min), 3);
    step(1, 0, 0);
    chk("acc_dirchg", 32'(set_min), 2);
    step(0, 0, 1);
    step(0, 0, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit b;
      bit l;
      bit r;
      if ($urandom_range(0, 199) == 0) idle(TO + 5);
      if ($urandom_range(0, 999) == 0) do_reset();
      cur_hour = 5'($urandom_range(0, 23));
      cur_min = 6'($urandom_range(0, 59));
      b = ($urandom_range(0, 99) < 5);
      l = ($urandom_range(0, 99) < 20);
      r = ($urandom_range(0, 99) < 20);
      step(l, r, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
